lsu_align_unit: RTL and testbench
=================================

Name: lsu_align_unit

Overview:
Load/store front-end placed directly upstream of the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and checks the address range. Aligned accesses go to memory as a single native access. Misaligned halfword/word accesses are split into sequential byte beats, and load results are reassembled with sign or zero extension. It lets the core issue unaligned accesses safely and reports out-of-range or illegal requests as errors.

Parameters:
MEM_NBYTE, 1024, size of the downstream data memory in bytes; legal byte addresses are 0..MEM_NBYTE-1.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, LSB-aligned
req_load_sel  in  3  `LOAD_SEL_B/BU/H/HU/W encoding from 0_macro.v
req_store_sel  in  2  `STORE_SEL_B/H/W encoding from 0_macro.v
rsp_valid  out  1  one-cycle pulse: request complete
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  request was out of range or had an illegal sel; valid with rsp_valid
rsp_split  out  1  request was executed as byte beats; valid with rsp_valid
mem_addr  out  32  to memory addr
mem_dataW  out  32  to memory write data
mem_load_sel  out  3  to memory load select
mem_store_sel  out  2  to memory store select
mem_wr_en  out  1  to memory write enable (`MEM_WRITE when writing)
mem_dataR  in  32  combinational read data from memory

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Handshake fires when req_valid && req_ready (cycle N). All request fields are captured into registers at that edge. req_valid while not IDLE is ignored.
- Size: B/BU = 1, H/HU = 2, W = 4. Alignment: B always aligned; H needs addr[0]==0; W needs addr[1:0]==0.
- Error: addr+size-1 >= MEM_NBYTE, computed in 33 bits so wrap past 0xFFFFFFFF counts as out of range. A load_sel/store_sel value outside the defined encodings is also an error.
- Error path: IDLE->RESP. No memory beat is issued and nothing is written. rsp at N+1 with rsp_err=1, rsp_rdata=0.
- Aligned path: IDLE->ACCESS for one beat in cycle N+1.
  - Beat signals: mem_addr=addr; mem_load_sel/mem_store_sel = captured sel.
  - Stores: mem_dataW=wdata; mem_wr_en=`MEM_WRITE.
  - Loads: mem_dataR is registered as the result.
  - rsp in cycle N+2.
- Split path: beat counter k=0..size-1, one beat per cycle from N+1. rsp in cycle N+1+size (half N+3, word N+5).
  - Beat signals: mem_addr=addr+k; mem_load_sel=`LOAD_SEL_BU; mem_store_sel=`STORE_SEL_B.
  - Stores: mem_dataW={24'b0, wdata byte k}; mem_wr_en=`MEM_WRITE.
  - Loads: mem_dataR[7:0] is written into byte k of the assembly register.
- Load extension at completion: B/H sign-extend from bit 7/15; BU/HU zero-extend; W is unmodified.
- RESP lasts exactly one cycle, then IDLE. req_ready is high again in the cycle after rsp_valid. Responses cannot be back-pressured.
- Outside ACCESS: mem_wr_en is not `MEM_WRITE; mem_addr, mem_dataW and mem_store_sel are 0; mem_load_sel=`LOAD_SEL_W.
- Reset (any state, including mid-split):
  - FSM->IDLE; counter and captured request cleared.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_split=0; req_ready=1 after the reset cycle.
  - Remaining beats are dropped; bytes already written stay written; no response is produced.

Test Plan:
- Memory bytes 0x10..0x13 = 44,33,22,11. LW 0x10 accepted at N -> one beat at N+1 (addr 0x10, `LOAD_SEL_W) -> rsp at N+2: rdata 0x11223344, err 0, split 0.
- SW 0xAABBCCDD to 0x21 -> byte-store beats at N+1..N+4 (addr 0x21..0x24, data DD,CC,BB,AA) -> rsp at N+5 with split=1. A following LW 0x21 returns 0xAABBCCDD with split=1.
- Bytes [3]=0x80, [4]=0xFF. LH 0x3 -> 0xFFFFFF80 after 2 beats, rsp at N+3. LHU 0x3 -> 0x0000FF80. LB 0x3 -> 0xFFFFFF80 via the aligned path at N+2.
- MEM_NBYTE=1024:
  - SW 1022 -> no mem_wr_en; rsp at N+1 with err=1, rdata 0.
  - SB 1023 -> normal write.
  - LW 0xFFFFFFFE -> err=1.
  - Illegal store_sel -> err=1.
- Misaligned SW 0x11223344 to 0x41; assert rst for one cycle after the 2nd beat -> mem 0x41=44, 0x42=33; 0x43/0x44 unchanged; no rsp_valid; req_ready=1 the next cycle.
- Hold req_valid high throughout a word split, changing fields mid-way -> only the first request executes. The second request is accepted in the cycle after rsp_valid.

Source files
------------

// File: rtl/lsu_align_unit.sv
// Load/store alignment front-end for a byte-addressed data memory.
// Native aligned accesses pass through as one beat. Misaligned halfword and
// word accesses are split into byte beats, and load bytes are reassembled
// before sign or zero extension. Out-of-range or illegal requests produce an
// error response and never touch memory.
module lsu_align_unit #(
  parameter int unsigned MEM_NBYTE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_load_sel,
  input  logic [1:0]  req_store_sel,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_split,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_dataW,
  output logic [2:0]  mem_load_sel,
  output logic [1:0]  mem_store_sel,
  output logic        mem_wr_en,
  input  logic [31:0] mem_dataR
);

  // Memory select encodings shared with the data memory.
  localparam logic [2:0] LOAD_SEL_B   = 3'd0;
  localparam logic [2:0] LOAD_SEL_BU  = 3'd1;
  localparam logic [2:0] LOAD_SEL_H   = 3'd2;
  localparam logic [2:0] LOAD_SEL_HU  = 3'd3;
  localparam logic [2:0] LOAD_SEL_W   = 3'd4;
  localparam logic [1:0] STORE_SEL_B  = 2'd0;
  localparam logic [1:0] STORE_SEL_H  = 2'd1;
  localparam logic [1:0] STORE_SEL_W  = 2'd2;
  localparam logic       MEM_WRITE    = 1'b1;
  localparam logic       MEM_READ     = 1'b0;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  lsel_q, lsel_d;
  logic [1:0]  ssel_q, ssel_d;
  logic        split_q, split_d;
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;
  logic [1:0]  last_k_q, last_k_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;

  logic [2:0]  req_size;
  logic        req_sel_ok;
  logic [32:0] req_end;
  logic        req_err;
  logic        req_misaligned;
  logic [31:0] asm_next;
  logic [7:0]  beat_byte;

  // Sign/zero extension of an LSB-aligned raw load value.
  function automatic logic [31:0] extend_load(input logic [2:0] sel, input logic [31:0] raw);
    case (sel)
      LOAD_SEL_B:  extend_load = {{24{raw[7]}}, raw[7:0]};
      LOAD_SEL_BU: extend_load = {24'b0, raw[7:0]};
      LOAD_SEL_H:  extend_load = {{16{raw[15]}}, raw[15:0]};
      LOAD_SEL_HU: extend_load = {16'b0, raw[15:0]};
      default:     extend_load = raw;
    endcase
  endfunction

  // Decode size, legality, range (33-bit so address wrap is caught) and alignment of the incoming request.
  always_comb begin
    req_size   = 3'd4;
    req_sel_ok = 1'b1;
    if (req_we) begin
      case (req_store_sel)
        STORE_SEL_B: req_size = 3'd1;
        STORE_SEL_H: req_size = 3'd2;
        STORE_SEL_W: req_size = 3'd4;
        default:     req_sel_ok = 1'b0;
      endcase
    end else begin
      case (req_load_sel)
        LOAD_SEL_B, LOAD_SEL_BU: req_size = 3'd1;
        LOAD_SEL_H, LOAD_SEL_HU: req_size = 3'd2;
        LOAD_SEL_W:              req_size = 3'd4;
        default:                 req_sel_ok = 1'b0;
      endcase
    end
    req_end        = {1'b0, req_addr} + {30'b0, req_size} - 33'd1;
    req_err        = !req_sel_ok || (req_end >= 33'(MEM_NBYTE));
    req_misaligned = ((req_size == 3'd2) && req_addr[0]) ||
                     ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
  end

  // Byte-beat helpers: assembly register with the current beat merged in, and the store byte for beat k.
  always_comb begin
    asm_next = asm_q;
    asm_next[{k_q, 3'b000} +: 8] = mem_dataR[7:0];
    beat_byte = wdata_q[{k_q, 3'b000} +: 8];
  end

  // Next-state logic for the request FSM, beat counter and response registers.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    lsel_d   = lsel_q;
    ssel_d   = ssel_q;
    split_d  = split_q;
    err_d    = err_q;
    k_d      = k_q;
    last_k_d = last_k_q;
    asm_d    = asm_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          lsel_d   = req_load_sel;
          ssel_d   = req_store_sel;
          err_d    = req_err;
          split_d  = !req_err && req_misaligned;
          k_d      = 2'd0;
          last_k_d = 2'(req_size - 3'd1);
          asm_d    = 32'd0;
          rdata_d  = 32'd0;
          state_d  = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (split_q) begin
          asm_d = asm_next;
          if (k_q == last_k_q) begin
            rdata_d = we_q ? 32'd0 : extend_load(lsel_q, asm_next);
            state_d = RESP;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else begin
          rdata_d = we_q ? 32'd0 : extend_load(lsel_q, mem_dataR);
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      lsel_q   <= 3'd0;
      ssel_q   <= 2'd0;
      split_q  <= 1'b0;
      err_q    <= 1'b0;
      k_q      <= 2'd0;
      last_k_q <= 2'd0;
      asm_q    <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      lsel_q   <= lsel_d;
      ssel_q   <= ssel_d;
      split_q  <= split_d;
      err_q    <= err_d;
      k_q      <= k_d;
      last_k_q <= last_k_d;
      asm_q    <= asm_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory beat drive; idle values outside ACCESS. Write enable is masked while reset is asserted
  // so the beat in flight during reset is dropped rather than written.
  always_comb begin
    mem_addr      = 32'd0;
    mem_dataW     = 32'd0;
    mem_load_sel  = LOAD_SEL_W;
    mem_store_sel = STORE_SEL_B;
    mem_wr_en     = MEM_READ;
    if (state_q == ACCESS) begin
      if (split_q) begin
        mem_addr      = addr_q + {30'b0, k_q};
        mem_load_sel  = LOAD_SEL_BU;
        mem_store_sel = STORE_SEL_B;
        mem_dataW     = we_q ? {24'b0, beat_byte} : 32'd0;
      end else begin
        mem_addr      = addr_q;
        mem_load_sel  = lsel_q;
        mem_store_sel = ssel_q;
        mem_dataW     = we_q ? wdata_q : 32'd0;
      end
      mem_wr_en = (we_q && !rst) ? MEM_WRITE : MEM_READ;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign rsp_split = split_q;

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit: byte memory model, scoreboard of
// expected responses (data, error, split flag, completion cycle).
module tb_lsu_align_unit;

  localparam logic [2:0] LS_B = 3'd0, LS_BU = 3'd1, LS_H = 3'd2, LS_HU = 3'd3, LS_W = 3'd4;
  localparam logic [1:0] SS_B = 2'd0, SS_H = 2'd1, SS_W = 2'd2;
  localparam int NBYTE = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_load_sel = 3'd0;
  logic [1:0]  req_store_sel = 2'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_split;
  logic [31:0] mem_addr;
  logic [31:0] mem_dataW;
  logic [2:0]  mem_load_sel;
  logic [1:0]  mem_store_sel;
  logic        mem_wr_en;
  logic [31:0] mem_dataR;

  lsu_align_unit #(.MEM_NBYTE(NBYTE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_sel(req_load_sel), .req_store_sel(req_store_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_split(rsp_split),
    .mem_addr(mem_addr), .mem_dataW(mem_dataW), .mem_load_sel(mem_load_sel),
    .mem_store_sel(mem_store_sel), .mem_wr_en(mem_wr_en), .mem_dataR(mem_dataR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  logic mem_init_done = 1'b0;
  logic [7:0] m [NBYTE];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        split;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rd(input logic [31:0] a);
    rd = (a < NBYTE) ? m[a[9:0]] : 8'h00;
  endfunction

  // Memory model: raw LSB-aligned read, zero-extended; byte/half/word writes.
  always_comb begin
    mem_dataR = 32'd0;
    case (mem_load_sel)
      LS_B, LS_BU: mem_dataR = {24'b0, rd(mem_addr)};
      LS_H, LS_HU: mem_dataR = {16'b0, rd(mem_addr + 1), rd(mem_addr)};
      default:     mem_dataR = {rd(mem_addr + 3), rd(mem_addr + 2), rd(mem_addr + 1), rd(mem_addr)};
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init_done) begin
      for (int i = 0; i < NBYTE; i++) m[i] <= 8'h00;
      m[3] <= 8'h80; m[4] <= 8'hFF;
      m[16] <= 8'h44; m[17] <= 8'h33; m[18] <= 8'h22; m[19] <= 8'h11;
      m[65] <= 8'hE1; m[66] <= 8'hE2; m[67] <= 8'hE3; m[68] <= 8'hE4;
      mem_init_done <= 1'b1;
    end else if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < NBYTE) m[mem_addr[9:0]] <= mem_dataW[7:0];
      if (mem_store_sel != SS_B && mem_addr + 1 < NBYTE) m[mem_addr[9:0] + 10'd1] <= mem_dataW[15:8];
      if (mem_store_sel == SS_W && mem_addr + 3 < NBYTE) begin
        m[mem_addr[9:0] + 10'd2] <= mem_dataW[23:16];
        m[mem_addr[9:0] + 10'd3] <= mem_dataW[31:24];
      end
    end
  end

  // Reference model of one request, evaluated against the memory model at acceptance.
  function automatic exp_t model(input logic we, input logic [31:0] a, input logic [2:0] ls,
                                 input logic [1:0] ss, input int n);
    exp_t e;
    int size;
    logic ok;
    logic [32:0] last;
    logic [31:0] raw;
    ok = 1'b1; size = 4;
    if (we) begin
      if (ss == SS_B) size = 1; else if (ss == SS_H) size = 2; else if (ss == SS_W) size = 4; else ok = 1'b0;
    end else begin
      if (ls == LS_B || ls == LS_BU) size = 1;
      else if (ls == LS_H || ls == LS_HU) size = 2;
      else if (ls == LS_W) size = 4;
      else ok = 1'b0;
    end
    last = {1'b0, a} + 33'(size) - 33'd1;
    e.err = !ok || (last >= 33'(NBYTE));
    e.split = !e.err && ((size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00));
    e.cyc = e.err ? n + 1 : (e.split ? n + 1 + size : n + 2);
    raw = 32'd0;
    for (int i = 0; i < 4; i++) if (i < size) raw[8*i +: 8] = rd(a + 32'(i));
    if (e.err || we) e.rdata = 32'd0;
    else case (ls)
      LS_B:    e.rdata = {{24{raw[7]}}, raw[7:0]};
      LS_H:    e.rdata = {{16{raw[15]}}, raw[15:0]};
      default: e.rdata = raw;
    endcase
    return e;
  endfunction

  // Response monitor: compare each completion against the scoreboard head.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_split", {31'b0, rsp_split}, {31'b0, e.split});
        check("rsp_cycle", cyc, e.cyc);
        $display("rsp: rdata=0x%08h err=%0b split=%0b cycle=%0d", rsp_rdata, rsp_err, rsp_split, cyc);
      end
    end
  end

  // Drive one request, wait (bounded) for acceptance, push the expectation; returns just after the accept edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] ls, input logic [1:0] ss, output int n);
    int t;
    @(negedge clk);
    req_we = we; req_addr = a; req_wdata = wd; req_load_sel = ls; req_store_sel = ss; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    check("accept_timeout", {31'b0, req_ready}, 32'd1);
    n = cyc;
    sb.push_back(model(we, a, ls, ss, n));
    $display("req: we=%0b addr=0x%08h wdata=0x%08h lsel=%0d ssel=%0d accepted cycle=%0d", we, a, wd, ls, ss, n);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || !req_ready) && t < 40) begin @(negedge clk); t++; end
    check("drain_timeout", sb.size(), 32'd0);
  endtask

  initial begin
    int n, n2, w0, t;
    logic [31:0] wv;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("idle_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("idle_load_sel", {29'b0, mem_load_sel}, {29'b0, LS_W});
    check("idle_addr", mem_addr, 32'd0);

    // Aligned word load with beat check.
    issue(1'b0, 32'h10, 32'd0, LS_W, SS_B, n);
    @(negedge clk);
    check("lw_beat_addr", mem_addr, 32'h10);
    check("lw_beat_sel", {29'b0, mem_load_sel}, {29'b0, LS_W});
    drain();

    // Misaligned word store: four byte beats.
    wv = 32'hAABBCCDD;
    issue(1'b1, 32'h21, wv, LS_W, SS_W, n);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("sw_split_addr", mem_addr, 32'h21 + 32'(k));
      check("sw_split_data", mem_dataW, {24'b0, wv[8*k +: 8]});
      check("sw_split_wr", {31'b0, mem_wr_en}, 32'd1);
    end
    drain();
    issue(1'b0, 32'h21, 32'd0, LS_W, SS_B, n);
    drain();

    // Extension cases.
    issue(1'b0, 32'h3, 32'd0, LS_H, SS_B, n);  drain();
    issue(1'b0, 32'h3, 32'd0, LS_HU, SS_B, n); drain();
    issue(1'b0, 32'h3, 32'd0, LS_B, SS_B, n);  drain();
    issue(1'b0, 32'h4, 32'd0, LS_BU, SS_B, n); drain();
    issue(1'b1, 32'h8, 32'h0000BEEF, LS_W, SS_H, n); drain();
    issue(1'b0, 32'h8, 32'd0, LS_H, SS_B, n); drain();

    // Range and legality errors.
    w0 = wr_cnt;
    issue(1'b1, 32'd1022, 32'h12345678, LS_W, SS_W, n); drain();
    check("err_no_write", wr_cnt, w0);
    issue(1'b1, 32'd1023, 32'h00000077, LS_W, SS_B, n); drain();
    check("sb_1023", {24'b0, m[1023]}, 32'h77);
    issue(1'b0, 32'hFFFFFFFE, 32'd0, LS_W, SS_B, n); drain();
    w0 = wr_cnt;
    issue(1'b1, 32'h40, 32'h1, LS_W, 2'd3, n); drain();
    check("illegal_ssel_no_write", wr_cnt, w0);
    issue(1'b0, 32'h40, 32'd0, 3'd5, SS_B, n); drain();

    // Reset in the middle of a split store.
    w0 = wr_cnt;
    issue(1'b1, 32'h41, 32'h11223344, LS_W, SS_W, n);
    t = 0;
    while (wr_cnt != w0 + 2 && t < 20) begin @(negedge clk); t++; end
    check("split_two_beats", wr_cnt, w0 + 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("rst_m41", {24'b0, m[65]}, 32'h44);
    check("rst_m42", {24'b0, m[66]}, 32'h33);
    check("rst_m43", {24'b0, m[67]}, 32'hE3);
    check("rst_m44", {24'b0, m[68]}, 32'hE4);

    // req_valid held through a split; fields change mid-way.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h31; req_wdata = 32'hCAFEBABE;
    req_load_sel = LS_W; req_store_sel = SS_W; req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    n = cyc;
    sb.push_back(model(1'b1, 32'h31, LS_W, SS_W, n));
    $display("req: held store addr=0x00000031 accepted cycle=%0d", n);
    n2 = -1;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) begin
        req_we = 1'b0; req_addr = 32'h31; req_load_sel = LS_W; req_store_sel = SS_B;
      end
      if (req_ready) begin
        n2 = cyc;
        sb.push_back(model(1'b0, 32'h31, LS_W, SS_B, n2));
        $display("req: held load addr=0x00000031 accepted cycle=%0d", n2);
        break;
      end
    end
    check("second_accept_cycle", n2, n + 6);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    @(negedge clk);
    check("end_idle_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("end_idle_dataW", mem_dataW, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
